// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter with optional lock,
// sequencing one access at a time onto memory_bus with a fixed read latency.
module mem_bus_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_address,
  input  logic [15:0] req0_data_in,
  input  logic [1:0]  req0_write_mask,
  input  logic        req0_write_enable,
  input  logic        req0_lock,
  input  logic        req1_valid,
  input  logic [15:0] req1_address,
  input  logic [15:0] req1_data_in,
  input  logic [1:0]  req1_write_mask,
  input  logic        req1_write_enable,
  input  logic        req1_lock,
  output logic        req0_ack,
  output logic        req1_ack,
  output logic        req0_done,
  output logic        req1_done,
  output logic [15:0] req0_rdata,
  output logic [15:0] req1_rdata,
  output logic [15:0] bus_address,
  output logic [15:0] bus_data_in,
  output logic [1:0]  bus_write_mask,
  output logic        bus_enable,
  output logic        bus_write_enable,
  input  logic [15:0] bus_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        owner, owner_n;
  logic        last_grant, last_grant_n;
  logic        lock_set, lock_set_n;
  logic        lock_id, lock_id_n;
  logic        lat_we, lat_we_n;
  logic        lat_lock, lat_lock_n;
  logic [15:0] address_n, data_n;
  logic [1:0]  mask_n;
  logic        enable_n, write_enable_n;
  logic        ack0_n, ack1_n, done0_n, done1_n;
  logic [15:0] rdata0_n, rdata1_n;
  logic        elig0, elig1, pick, fin, smp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      owner            <= 1'b0;
      last_grant       <= 1'b1;
      lock_set         <= 1'b0;
      lock_id          <= 1'b0;
      lat_we           <= 1'b0;
      lat_lock         <= 1'b0;
      bus_address      <= '0;
      bus_data_in      <= '0;
      bus_write_mask   <= '0;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
      req0_ack         <= 1'b0;
      req1_ack         <= 1'b0;
      req0_done        <= 1'b0;
      req1_done        <= 1'b0;
      req0_rdata       <= '0;
      req1_rdata       <= '0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      owner            <= owner_n;
      last_grant       <= last_grant_n;
      lock_set         <= lock_set_n;
      lock_id          <= lock_id_n;
      lat_we           <= lat_we_n;
      lat_lock         <= lat_lock_n;
      bus_address      <= address_n;
      bus_data_in      <= data_n;
      bus_write_mask   <= mask_n;
      bus_enable       <= enable_n;
      bus_write_enable <= write_enable_n;
      req0_ack         <= ack0_n;
      req1_ack         <= ack1_n;
      req0_done        <= done0_n;
      req1_done        <= done1_n;
      req0_rdata       <= rdata0_n;
      req1_rdata       <= rdata1_n;
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    owner_n        = owner;
    last_grant_n   = last_grant;
    lock_set_n     = lock_set;
    lock_id_n      = lock_id;
    lat_we_n       = lat_we;
    lat_lock_n     = lat_lock;
    address_n      = bus_address;
    data_n         = bus_data_in;
    mask_n         = bus_write_mask;
    enable_n       = 1'b0;
    write_enable_n = 1'b0;
    ack0_n         = 1'b0;
    ack1_n         = 1'b0;
    done0_n        = 1'b0;
    done1_n        = 1'b0;
    rdata0_n       = req0_rdata;
    rdata1_n       = req1_rdata;
    fin            = 1'b0;
    smp            = 1'b0;
    // a held lock masks out the other requester
    elig0 = req0_valid && (!lock_set || !lock_id);
    elig1 = req1_valid && (!lock_set || lock_id);
    pick  = (elig0 && elig1) ? ~last_grant : elig1;

    unique case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          owner_n        = pick;
          last_grant_n   = pick;
          address_n      = pick ? req1_address : req0_address;
          data_n         = pick ? req1_data_in : req0_data_in;
          mask_n         = pick ? req1_write_mask : req0_write_mask;
          lat_we_n       = pick ? req1_write_enable : req0_write_enable;
          lat_lock_n     = pick ? req1_lock : req0_lock;
          cnt_n          = CNT_INIT;
          enable_n       = 1'b1;
          write_enable_n = lat_we_n;
          ack0_n         = !pick;
          ack1_n         = pick;
          state_n        = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_we) begin
          fin = 1'b1;
        end else if (cnt == 3'd0) begin
          fin = 1'b1;
          smp = 1'b1;
        end else begin
          cnt_n   = cnt - 3'd1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          fin = 1'b1;
          smp = 1'b1;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (fin) begin
      state_n    = IDLE;
      lock_set_n = lat_lock;
      lock_id_n  = owner;
      done0_n    = !owner;
      done1_n    = owner;
      if (smp && !owner) rdata0_n = bus_data_out;
      if (smp && owner)  rdata1_n = bus_data_out;
    end
  end

endmodule
